// File: rtl/ram_arbiter_if.sv
// ============================================================================
// ram_arbiter_if : requester A/B and RAM-side signals of the two-port arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view: requests and RAM read data in, grants/responses/RAM controls out.
  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
           mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
           mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : independent write-port and read-port arbitration of one RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic wr_a, wr_b, rd_a, rd_b;
  logic wr_any, rd_any;
  logic wr_win, rd_win;
  logic last_wr, last_rd;
  logic resp_vld, resp_port;

  always_comb begin
    wr_a   = bus.req_a & bus.we_a;
    wr_b   = bus.req_b & bus.we_b;
    rd_a   = bus.req_a & ~bus.we_a;
    rd_b   = bus.req_b & ~bus.we_b;
    wr_any = (wr_a | wr_b) & ~rst;
    rd_any = (rd_a | rd_b) & ~rst;
    // On conflict, round-robin hands the port to whoever did not win it last.
    if (wr_a & wr_b) wr_win = FIXED_PRIO ? PORT_A : ~last_wr;
    else             wr_win = wr_b ? PORT_B : PORT_A;
    if (rd_a & rd_b) rd_win = FIXED_PRIO ? PORT_A : ~last_rd;
    else             rd_win = rd_b ? PORT_B : PORT_A;
  end

  assign bus.gnt_a = (wr_any & (wr_win == PORT_A)) | (rd_any & (rd_win == PORT_A));
  assign bus.gnt_b = (wr_any & (wr_win == PORT_B)) | (rd_any & (rd_win == PORT_B));

  assign bus.mem_we    = wr_any;
  assign bus.mem_waddr = wr_any ? ((wr_win == PORT_B) ? bus.addr_b : bus.addr_a) : '0;
  assign bus.mem_wdata = wr_any ? ((wr_win == PORT_B) ? bus.wdata_b : bus.wdata_a) : '0;
  assign bus.mem_re    = rd_any;
  assign bus.mem_raddr = rd_any ? ((rd_win == PORT_B) ? bus.addr_b : bus.addr_a) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr   <= PORT_B;
      last_rd   <= PORT_B;
      resp_vld  <= 1'b0;
      resp_port <= PORT_A;
    end else begin
      if (wr_any) last_wr <= wr_win;
      if (rd_any) last_rd <= rd_win;
      resp_vld  <= rd_any;
      resp_port <= rd_win;
    end
  end

  // The RAM registers its own read data, so the tag only has to line up with it.
  assign bus.rvalid_a = resp_vld & (resp_port == PORT_A);
  assign bus.rvalid_b = resp_vld & (resp_port == PORT_B);
  assign bus.rdata_a  = bus.mem_rdata;
  assign bus.rdata_b  = bus.mem_rdata;
endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : round-robin and fixed-priority arbiters on a shared stimulus
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  logic [7:0] q0, q1;

  assign if0.req_a = req_a;   assign if1.req_a = req_a;
  assign if0.req_b = req_b;   assign if1.req_b = req_b;
  assign if0.we_a = we_a;     assign if1.we_a = we_a;
  assign if0.we_b = we_b;     assign if1.we_b = we_b;
  assign if0.addr_a = addr_a; assign if1.addr_a = addr_a;
  assign if0.addr_b = addr_b; assign if1.addr_b = addr_b;
  assign if0.wdata_a = wdata_a; assign if1.wdata_a = wdata_a;
  assign if0.wdata_b = wdata_b; assign if1.wdata_b = wdata_b;
  assign if0.mem_rdata = q0;  assign if1.mem_rdata = q1;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst(rst), .bus(if0));
  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst(rst), .bus(if1));

  function automatic logic [7:0] pat(input int i);
    if (i == 16) return 8'h5A;
    if (i == 64) return 8'h01;
    return 8'(i * 3 + 7);
  endfunction

  // Registered-read RAMs, read-before-write, reloaded with a known pattern during reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram0[i] <= pat(i);
    end else begin
      if (if0.mem_re) q0 <= ram0[if0.mem_raddr];
      if (if0.mem_we) ram0[if0.mem_waddr] <= if0.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram1[i] <= pat(i);
    end else begin
      if (if1.mem_re) q1 <= ram1[if1.mem_raddr];
      if (if1.mem_we) ram1[if1.mem_waddr] <= if1.mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Model state per instance: memory image, last winners (0=A,1=B), pending response.
  logic [7:0] ref_mem [2][256];
  logic       lw [2] = '{1'b1, 1'b1};
  logic       lr [2] = '{1'b1, 1'b1};
  logic       pv [2] = '{1'b0, 1'b0};
  logic       pp [2] = '{1'b0, 1'b0};
  logic [7:0] pd [2] = '{8'h00, 8'h00};

  task automatic model_check(input int k, input logic g_a, g_b, rv_a, rv_b,
                             input logic [7:0] rdat_a, rdat_b, input logic m_we,
                             input logic [7:0] m_wa, m_wd, input logic m_re,
                             input logic [7:0] m_ra);
    string s;
    logic wa, wb, ra, rb, hw, hr, ww, wr;
    logic [7:0] e_wa, e_wd, e_ra;
    s = (k == 0) ? "rr" : "fp";
    chk({s, ".rvalid_a"}, rv_a, pv[k] && !pp[k]);
    chk({s, ".rvalid_b"}, rv_b, pv[k] && pp[k]);
    if (pv[k]) chk({s, ".rdata"}, pp[k] ? rdat_b : rdat_a, pd[k]);
    wa = req_a & we_a;  wb = req_b & we_b;
    ra = req_a & !we_a; rb = req_b & !we_b;
    hw = !rst && (wa || wb);
    hr = !rst && (ra || rb);
    ww = (wa && wb) ? ((k == 1) ? 1'b0 : !lw[k]) : wb;
    wr = (ra && rb) ? ((k == 1) ? 1'b0 : !lr[k]) : rb;
    e_wa = hw ? (ww ? addr_b : addr_a) : 8'h00;
    e_wd = hw ? (ww ? wdata_b : wdata_a) : 8'h00;
    e_ra = hr ? (wr ? addr_b : addr_a) : 8'h00;
    chk({s, ".gnt_a"}, g_a, (hw && !ww) || (hr && !wr));
    chk({s, ".gnt_b"}, g_b, (hw && ww) || (hr && wr));
    chk({s, ".mem_we"}, m_we, hw);
    chk({s, ".mem_waddr"}, m_wa, e_wa);
    chk({s, ".mem_wdata"}, m_wd, e_wd);
    chk({s, ".mem_re"}, m_re, hr);
    chk({s, ".mem_raddr"}, m_ra, e_ra);
    if (rst) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = pat(i);
      lw[k] = 1'b1; lr[k] = 1'b1; pv[k] = 1'b0;
    end else begin
      pv[k] = hr;
      pp[k] = wr;
      if (hr) begin pd[k] = ref_mem[k][e_ra]; lr[k] = wr; end
      if (hw) begin ref_mem[k][e_wa] = e_wd; lw[k] = ww; end
    end
  endtask

  always @(negedge clk) begin
    model_check(0, if0.gnt_a, if0.gnt_b, if0.rvalid_a, if0.rvalid_b, if0.rdata_a, if0.rdata_b,
                if0.mem_we, if0.mem_waddr, if0.mem_wdata, if0.mem_re, if0.mem_raddr);
    model_check(1, if1.gnt_a, if1.gnt_b, if1.rvalid_a, if1.rvalid_b, if1.rdata_a, if1.rdata_b,
                if1.mem_we, if1.mem_waddr, if1.mem_wdata, if1.mem_re, if1.mem_raddr);
  end

  task automatic step(input logic r, input logic qa, wea, input logic [7:0] aa, da,
                      input logic qb, web, input logic [7:0] ab, db);
    @(posedge clk);
    #1;
    rst = r;
    req_a = qa; we_a = wea; addr_a = aa; wdata_a = da;
    req_b = qb; we_b = web; addr_b = ab; wdata_b = db;
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10; wdata_a = 8'h00;
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'h40; wdata_b = 8'h00;
    // Reset held two cycles with both requesting
    @(negedge clk);
    chk("lit.rst.gnt_a", if0.gnt_a, 0);
    chk("lit.rst.gnt_b", if1.gnt_b, 0);
    chk("lit.rst.mem_re", if0.mem_re, 0);
    chk("lit.rst.rvalid_a", if0.rvalid_a, 0);
    @(negedge clk);
    chk("lit.rst2.gnt_a", if1.gnt_a, 0);
    chk("lit.rst2.mem_we", if0.mem_we, 0);

    // Simple read of 0x10 by A
    step(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit.rd.gnt_a", if0.gnt_a, 1);
    chk("lit.rd.mem_raddr", if0.mem_raddr, 8'h10);
    // Parallel: A writes 0x22 to 0x30, B reads 0x31
    step(0, 1, 1, 8'h30, 8'h22, 1, 0, 8'h31, 8'h00);
    @(negedge clk);
    chk("lit.rd.rvalid_a", if0.rvalid_a, 1);
    chk("lit.rd.rdata_a", if0.rdata_a, 8'h5A);
    chk("lit.rd.rvalid_b", if0.rvalid_b, 0);
    chk("lit.par.gnt_a", if0.gnt_a, 1);
    chk("lit.par.gnt_b", if0.gnt_b, 1);
    chk("lit.par.mem_we", if0.mem_we, 1);
    chk("lit.par.mem_re", if0.mem_re, 1);
    step(0, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit.par.rvalid_b", if0.rvalid_b, 1);
    chk("lit.par.rdata_b", if0.rdata_b, 8'h9A);
    // B-only read leaves last_rd = B ahead of the contention run
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00);
    @(negedge clk);
    chk("lit.par.rdback", if0.rdata_a, 8'h22);

    // Read contention for four cycles
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h30, 8'h00, 1, 0, 8'h10, 8'h00);
      @(negedge clk);
      chk($sformatf("lit.cont%0d.rr.gnt_a", i), if0.gnt_a, (i % 2) == 0);
      chk($sformatf("lit.cont%0d.fp.gnt_a", i), if1.gnt_a, 1);
    end

    // Same-address write/read hazard
    step(0, 1, 1, 8'h40, 8'hFF, 1, 0, 8'h40, 8'h00);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
    @(negedge clk);
    chk("lit.haz.old", if0.rdata_b, 8'h01);
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit.haz.new", if1.rdata_b, 8'hFF);

    // Write contention for two cycles
    step(0, 1, 1, 8'h50, 8'h11, 1, 1, 8'h51, 8'h33);
    step(0, 1, 1, 8'h50, 8'h11, 1, 1, 8'h51, 8'h33);

    // Reset arriving right after a granted read
    step(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit.rstrd.rvalid_a", if0.rvalid_a, 1);
    step(0, 1, 0, 8'h10, 8'h00, 1, 0, 8'h40, 8'h00);
    @(negedge clk);
    chk("lit.rstrd.rvalid_a2", if0.rvalid_a, 0);
    chk("lit.rstrd.rr.gnt_a", if0.gnt_a, 1);
    chk("lit.rstrd.fp.gnt_a", if1.gnt_a, 1);
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit.rstrd.rdata_a", if0.rdata_a, 8'h5A);
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-clock 8-bit RAM between the instruction-fetch requester (port A) and the load/store requester (port B). The RAM's independent write and read ports are arbitrated separately, so one write and one read proceed in the same cycle. When both requesters want the same RAM port, the arbiter resolves the conflict round-robin or with fixed priority, and returns each read response to its owner one cycle after grant.

## Interface
- ADDR_W, 8, address width (RAM depth 2^ADDR_W)
- DATA_W, 8, data width
- FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = port A always wins
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_a / req_b  in  1  access request; held with we/addr/wdata stable until gnt seen
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  access address
- wdata_a / wdata_b  in  DATA_W  write data
- gnt_a / gnt_b  out  1  combinational grant, access issued this cycle
- rvalid_a / rvalid_b  out  1  read data valid for that port
- rdata_a / rdata_b  out  DATA_W  read data; both equal mem_rdata, meaningful only with rvalid
- mem_we  out  1  RAM write enable
- mem_waddr  out  ADDR_W  RAM write address
- mem_wdata  out  DATA_W  RAM write data
- mem_re  out  1  RAM read enable
- mem_raddr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM registered read data, valid the cycle after mem_re

## Operation
- Each cycle, write requests (req_x & we_x) compete for the write port and read requests (req_x & !we_x) compete for the read port. The two classes never block each other.
- Single candidate on a port: it is granted.
- Two candidates on a port (both write or both read): FIXED_PRIO=1 grants A. FIXED_PRIO=0 grants the port opposite to last_wr (write port) or last_rd (read port).
- last_wr and last_rd are 1-bit registers that record the winner of every grant on that RAM port, contested or not. Reset value is B, so A wins the first conflict.
- Write grant: mem_we=1, mem_waddr/mem_wdata taken from the winner. Otherwise mem_we=0 and mem_waddr/mem_wdata=0.
- Read grant: mem_re=1, mem_raddr taken from the winner. Otherwise mem_re=0 and mem_raddr=0.
- The response register resp_vld/resp_port is loaded every cycle with the read grant. In the next cycle it drives rvalid_a = resp_vld & (resp_port==A), and likewise rvalid_b.
- Read and write to the same address in one cycle: the read returns the pre-write value (read-before-write). The new value is visible to a read granted in the following cycle.
- No request queueing. An ungranted requester keeps req high and retries each cycle.

## Timing
- Grant latency: 0 cycles; gnt in the same cycle as req when uncontested. A write commits at the end of the grant cycle.
- Read latency: rvalid exactly 1 cycle after gnt. Throughput is 1 read and 1 write per cycle.
- Max wait under round-robin with continuous contention: 1 cycle.
- While rst=1: gnt_a, gnt_b, mem_we and mem_re are forced 0 combinationally. The rst edge clears resp_vld, last_wr:=B and last_rd:=B.
- Reset outputs: gnt=0, rvalid=0, mem_we=0, mem_re=0, all address/data outputs 0.
- Reset mid-operation: a read granted in cycle N with rst first high in N+1 still shows rvalid in N+1, because the register was loaded before rst was sampled. rvalid is 0 from N+2.
- A request held across reset is first considered in the first cycle with rst=0.

## Test plan
- Reset: rst high 2 cycles with req_a=req_b=1 -> gnt, mem_we, mem_re all 0; rvalid=0 in the cycle after the first rst edge.
- Simple read: req_a, read addr 0x10, mem holds 0x5A -> gnt_a in cycle N, mem_raddr=0x10; rvalid_a=1, rdata_a=0x5A in N+1; rvalid_b=0.
- Parallel: A writes 0x22 to 0x30 while B reads 0x31 in the same cycle -> both granted, mem_we=mem_re=1; rvalid_b next cycle. A later read of 0x30 returns 0x22.
- Read contention, FIXED_PRIO=0, both reading continuously for 4 cycles -> grants A,B,A,B, each rvalid tagged to the right port. With FIXED_PRIO=1 -> A,A,A,A.
- Hazard: A writes 0xFF to 0x40 while B reads 0x40 (old value 0x01) -> rdata_b=0x01. B reads 0x40 again next cycle -> 0xFF.
- Reset mid-read: grant A read in N, rst=1 in N+1 -> rvalid_a=1 in N+1, 0 in N+2. last_rd is B again, so A wins the next conflict.
